sfx_clip_player: RTL and testbench

Parametrised multi-clip sound-effect sequencer. It sits between the game logic and the shared audio ROM plus the PWM generator. It plays any of `CLIPS` stored clips out of one sample ROM, with priority pre-emption, optional looping, stop, and volume attenuation. Each output sample is emitted with a one-cycle valid tick at `CLK_HZ/SAMPLE_HZ`, ready for `pwm_audio_generator`.

---
 rtl/sfx_pkg.sv | 36 +++
 rtl/sfx_rate_divider.sv | 27 ++
 rtl/sfx_clip_player.sv | 194 +++++++++++++++++++
 tb/tb_sfx_clip_player.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared types, attenuation helper and the game's clip table for the sound-effect player.
package sfx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitTick,
        StFetch,
        StCapture
    } sfx_state_t;

    localparam int unsigned SFX_CLIPS  = 4;
    localparam int unsigned SFX_ADDR_W = 18;

    localparam int unsigned SFX_YAY   = 0;
    localparam int unsigned SFX_JUMP  = 1;
    localparam int unsigned SFX_GEM   = 2;
    localparam int unsigned SFX_DEATH = 3;

    // Packed as {DEATH, GEM, JUMP, YAY}; clips sit back to back in the ROM.
    localparam logic [SFX_CLIPS*SFX_ADDR_W-1:0] SFX_CLIP_BASE =
        {18'h0ABE0, 18'h08CA0, 18'h07D00, 18'h00000};
    localparam logic [SFX_CLIPS*SFX_ADDR_W-1:0] SFX_CLIP_LEN  =
        {18'h03E80, 18'h01F40, 18'h00FA0, 18'h07D00};

    // Operates on a sample left-aligned in 16 bits, so any sample width up to 16 can use it
    // by taking the top bits of the result.
    function automatic logic [15:0] sfx_attenuate(input logic [15:0] sample,
                                                  input logic [1:0]  vol);
        logic signed [16:0] centred;
        logic signed [16:0] scaled;
        centred = $signed({1'b0, sample}) - 17'sd32768;
        scaled  = (centred >>> vol) + 17'sd32768;
        return scaled[15:0];
    endfunction

endpackage

// File: rtl/sfx_rate_divider.sv
// Free-running sample-rate divider: one-cycle rate_tick every DIV clocks.
module sfx_rate_divider #(
    parameter int unsigned DIV = 6250
) (
    input  logic CLK,
    input  logic RESET_N,
    output logic rate_tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q;

    assign rate_tick = (cnt_q == CntLast);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else if (rate_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/sfx_clip_player.sv
// Multi-clip sound-effect sequencer: reads clips from a shared sample ROM at the sample rate,
// with priority pre-emption, looping, stop and volume attenuation.
module sfx_clip_player
    import sfx_pkg::*;
#(
    parameter int unsigned CLIPS    = 4,
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned DIV      = 6250,
    parameter int unsigned ROM_LAT  = 1,
    parameter logic [CLIPS*ADDR_W-1:0] CLIP_BASE = SFX_CLIP_BASE,
    parameter logic [CLIPS*ADDR_W-1:0] CLIP_LEN  = SFX_CLIP_LEN
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       trig,
    input  logic [$clog2(CLIPS)-1:0]   trig_id,
    input  logic                       trig_loop,
    input  logic                       stop,
    input  logic [1:0]                 vol,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [SAMPLE_W-1:0]        rom_data,
    output logic [SAMPLE_W-1:0]        audio_sample_out,
    output logic                       sample_tick,
    output logic                       trig_ack,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(CLIPS)-1:0]   cur_id
);

    localparam int unsigned IdW = $clog2(CLIPS);
    localparam logic [SAMPLE_W-1:0] Mid = {1'b1, {(SAMPLE_W-1){1'b0}}};

    sfx_state_t          state_q, state_d;
    logic [1:0]          fetch_cnt_q, fetch_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic                loop_q, loop_d;
    logic                busy_q, busy_d;
    logic [IdW-1:0]      cur_id_q, cur_id_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                tick_q, tick_d;
    logic                ack_q, ack_d;
    logic                done_q, done_d;
    logic                mid_pending_q, mid_pending_d;

    logic                rate_tick;
    logic                accept;
    logic [ADDR_W-1:0]   trig_base, trig_len;
    logic [15:0]         rom_data_al, att_al;
    logic [SAMPLE_W-1:0] att_sample;

    sfx_rate_divider #(
        .DIV(DIV)
    ) u_rate_divider (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .rate_tick(rate_tick)
    );

    assign trig_base   = CLIP_BASE[trig_id * ADDR_W +: ADDR_W];
    assign trig_len    = CLIP_LEN[trig_id * ADDR_W +: ADDR_W];
    assign accept      = trig && !stop && ((state_q == StIdle) || (trig_id <= cur_id_q));
    assign rom_data_al = 16'(rom_data) << (16 - SAMPLE_W);
    assign att_al      = sfx_attenuate(rom_data_al, vol);
    assign att_sample  = att_al[15 -: SAMPLE_W];

    always_comb begin
        state_d       = state_q;
        fetch_cnt_d   = fetch_cnt_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        base_d        = base_q;
        len_d         = len_q;
        loop_d        = loop_q;
        busy_d        = busy_q;
        cur_id_d      = cur_id_q;
        sample_d      = sample_q;
        mid_pending_d = mid_pending_q;
        tick_d        = 1'b0;
        ack_d         = 1'b0;
        done_d        = 1'b0;

        if (stop) begin
            state_d       = StIdle;
            busy_d        = 1'b0;
            sample_d      = Mid;
            tick_d        = 1'b1;
            mid_pending_d = 1'b0;
        end else if (accept) begin
            // Loading a new clip abandons any fetch already under way.
            state_d       = StWaitTick;
            addr_d        = trig_base;
            remaining_d   = trig_len;
            base_d        = trig_base;
            len_d         = trig_len;
            loop_d        = trig_loop;
            busy_d        = 1'b1;
            cur_id_d      = trig_id;
            ack_d         = 1'b1;
            mid_pending_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rate_tick && mid_pending_q) begin
                        sample_d      = Mid;
                        tick_d        = 1'b1;
                        mid_pending_d = 1'b0;
                    end
                end
                StWaitTick: begin
                    if (rate_tick) begin
                        state_d     = StFetch;
                        fetch_cnt_d = '0;
                    end
                end
                StFetch: begin
                    // The sample register loads as FETCH ends, so the tick is visible in CAPTURE.
                    if (fetch_cnt_q == 2'(ROM_LAT - 1)) begin
                        state_d  = StCapture;
                        sample_d = att_sample;
                        tick_d   = 1'b1;
                    end else begin
                        fetch_cnt_d = fetch_cnt_q + 2'd1;
                    end
                end
                StCapture: begin
                    if (remaining_q == ADDR_W'(1)) begin
                        if (loop_q) begin
                            state_d     = StWaitTick;
                            addr_d      = base_q;
                            remaining_d = len_q;
                        end else begin
                            state_d       = StIdle;
                            busy_d        = 1'b0;
                            done_d        = 1'b1;
                            mid_pending_d = 1'b1;
                        end
                    end else begin
                        state_d     = StWaitTick;
                        addr_d      = addr_q + ADDR_W'(1);
                        remaining_d = remaining_q - ADDR_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= StIdle;
            fetch_cnt_q   <= '0;
            addr_q        <= '0;
            remaining_q   <= '0;
            base_q        <= '0;
            len_q         <= '0;
            loop_q        <= 1'b0;
            busy_q        <= 1'b0;
            cur_id_q      <= '0;
            sample_q      <= Mid;
            tick_q        <= 1'b0;
            ack_q         <= 1'b0;
            done_q        <= 1'b0;
            mid_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_cnt_q   <= fetch_cnt_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            base_q        <= base_d;
            len_q         <= len_d;
            loop_q        <= loop_d;
            busy_q        <= busy_d;
            cur_id_q      <= cur_id_d;
            sample_q      <= sample_d;
            tick_q        <= tick_d;
            ack_q         <= ack_d;
            done_q        <= done_d;
            mid_pending_q <= mid_pending_d;
        end
    end

    assign rom_addr         = addr_q;
    assign audio_sample_out = sample_q;
    assign sample_tick      = tick_q;
    assign trig_ack         = ack_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign cur_id           = cur_id_q;

endmodule

// File: tb/tb_sfx_clip_player.sv
// Bench for sfx_clip_player: timing-rule model checked every cycle plus directed literal checks.
module tb_sfx_clip_player;

    localparam int DIV     = 8;
    localparam int ROM_LAT = 1;
    localparam logic [71:0] TB_BASE = {18'h300, 18'h200, 18'h100, 18'h000};
    localparam logic [71:0] TB_LEN  = {18'd3, 18'd4, 18'd2, 18'd5};

    int base_tab[4] = '{'h000, 'h100, 'h200, 'h300};
    int len_tab[4]  = '{5, 2, 4, 3};
    int t2_exp[10]  = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        trig = 1'b0;
    logic [1:0]  trig_id = 2'd0;
    logic        trig_loop = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  vol = 2'd0;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic [7:0]  audio_sample_out;
    logic        sample_tick, trig_ack, busy, done;
    logic [1:0]  cur_id;

    int n_vec = 0;
    int n_err = 0;
    int tb_cyc = 0;

    logic       ovr_en = 1'b0;
    logic [7:0] ovr_val = 8'h00;

    sfx_clip_player #(
        .CLIPS    (4),
        .ADDR_W   (18),
        .SAMPLE_W (8),
        .DIV      (DIV),
        .ROM_LAT  (ROM_LAT),
        .CLIP_BASE(TB_BASE),
        .CLIP_LEN (TB_LEN)
    ) dut (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .trig            (trig),
        .trig_id         (trig_id),
        .trig_loop       (trig_loop),
        .stop            (stop),
        .vol             (vol),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .audio_sample_out(audio_sample_out),
        .sample_tick     (sample_tick),
        .trig_ack        (trig_ack),
        .busy            (busy),
        .done            (done),
        .cur_id          (cur_id)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] rom_byte(input logic [17:0] a);
        return ovr_en ? ovr_val : a[7:0];
    endfunction

    // One-cycle-latency behavioural ROM.
    always @(posedge CLK) rom_data <= rom_byte(rom_addr);
    always @(posedge CLK) tb_cyc <= tb_cyc + 1;

    function automatic int atten(input int b, input int v);
        int c;
        c = b - 128;
        return (c >>> v) + 128;
    endfunction

    // First cycle strictly after n in which the divider is at its last count.
    function automatic int next_tick(input int n);
        return ((n + 1) / DIV) * DIV + DIV - 1;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: expected outputs for the next cycle, derived from cycle-time arithmetic.
    int          n, m_pos, m_len, m_base, cap_at, adv_at;
    bit          m_loop, mid_pend;
    logic [17:0] e_addr;
    logic [7:0]  e_sample;
    logic        e_tick, e_ack, e_busy, e_done;
    logic [1:0]  e_cur_id;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            n = 0; m_pos = 0; m_len = 0; m_base = 0; cap_at = -1; adv_at = -1;
            m_loop = 0; mid_pend = 0;
            e_addr = '0; e_sample = 8'h80; e_tick = 0; e_ack = 0; e_busy = 0; e_done = 0;
            e_cur_id = '0;
        end else begin
            bit rt, acc;
            rt  = (n % DIV) == DIV - 1;
            acc = trig && !stop && (!e_busy || trig_id <= e_cur_id);
            e_tick = 0; e_ack = 0; e_done = 0;
            if (stop) begin
                e_busy = 0; e_sample = 8'h80; e_tick = 1; mid_pend = 0;
                cap_at = -1; adv_at = -1;
            end else if (acc) begin
                e_ack = 1; e_busy = 1; e_cur_id = trig_id; m_loop = trig_loop;
                m_base = base_tab[trig_id]; m_len = len_tab[trig_id]; m_pos = 0;
                e_addr = 18'(m_base); mid_pend = 0; adv_at = -1;
                cap_at = next_tick(n) + ROM_LAT;
            end else if (n == cap_at) begin
                e_sample = 8'(atten(int'(rom_byte(e_addr)), int'(vol)));
                e_tick = 1; adv_at = n + 1; cap_at = -1;
            end else if (n == adv_at) begin
                adv_at = -1;
                if (m_pos == m_len - 1) begin
                    if (m_loop) begin
                        m_pos = 0; e_addr = 18'(m_base); cap_at = next_tick(n) + ROM_LAT;
                    end else begin
                        e_done = 1; e_busy = 0; mid_pend = 1;
                    end
                end else begin
                    m_pos++; e_addr = 18'(m_base + m_pos); cap_at = next_tick(n) + ROM_LAT;
                end
            end else if (mid_pend && rt && !e_busy) begin
                e_sample = 8'h80; e_tick = 1; mid_pend = 0;
            end
            n++;
        end
    end

    always @(negedge CLK) begin
        check("rom_addr", rom_addr, e_addr);
        check("audio_sample_out", audio_sample_out, e_sample);
        check("sample_tick", sample_tick, e_tick);
        check("trig_ack", trig_ack, e_ack);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("cur_id", cur_id, e_cur_id);
    end

    task automatic pulse_trig(input logic [1:0] id, input logic lp);
        @(posedge CLK); #1;
        trig = 1'b1; trig_id = id; trig_loop = lp;
        @(posedge CLK); #1;
        trig = 1'b0; trig_loop = 1'b0;
    endtask

    task automatic wait_sample(output logic [7:0] v, output int at);
        bit seen;
        seen = 0; v = 8'h00; at = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (sample_tick) begin
                seen = 1; v = audio_sample_out; at = tb_cyc;
            end
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL sample_wait: no sample_tick within 40 cycles (t=%0t)", $time);
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (done) seen = 1;
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL done_wait: no done pulse within 40 cycles (t=%0t)", $time);
        end
    endtask

    initial begin
        logic [7:0] v;
        int at, prev, ticks;
        prev = 0;
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_audio", audio_sample_out, 8'h80);
        check("rst_busy", busy, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_tick", sample_tick, 0);
        #6 RESET_N = 1'b1;

        // 1: clip 0, one-shot
        pulse_trig(2'd0, 1'b0);
        check("t1_ack", trig_ack, 1);
        for (int i = 0; i < 5; i++) begin
            wait_sample(v, at);
            check("t1_sample", v, i);
            if (i > 0) check("t1_cadence", at - prev, 8);
            prev = at;
        end
        wait_done();
        check("t1_busy_after_done", busy, 0);
        wait_sample(v, at);
        check("t1_mid_return", v, 8'h80);

        // 2: clip 2 looping, then stop
        pulse_trig(2'd2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            wait_sample(v, at);
            check("t2_loop_sample", v, t2_exp[i]);
        end
        @(posedge CLK); #1 stop = 1'b1;
        @(posedge CLK); #1 stop = 1'b0;
        check("t2_stop_audio", audio_sample_out, 8'h80);
        check("t2_stop_busy", busy, 0);
        check("t2_stop_tick", sample_tick, 1);

        // 3: priority
        pulse_trig(2'd2, 1'b1);
        wait_sample(v, at);
        check("t3_first", v, 8'h00);
        pulse_trig(2'd3, 1'b0);
        check("t3_low_prio_ack", trig_ack, 0);
        check("t3_low_prio_id", cur_id, 2);
        wait_sample(v, at);
        check("t3_continue", v, 8'h01);
        pulse_trig(2'd1, 1'b0);
        check("t3_high_prio_ack", trig_ack, 1);
        check("t3_high_prio_addr", rom_addr, 18'h100);
        wait_sample(v, at);
        check("t3_new_clip", v, 8'h00);
        wait_sample(v, at);
        check("t3_new_clip2", v, 8'h01);
        wait_done();
        wait_sample(v, at);
        check("t3_mid_return", v, 8'h80);

        // 4: attenuation
        ovr_en = 1'b1; ovr_val = 8'hFF; vol = 2'd2;
        pulse_trig(2'd3, 1'b0);
        wait_sample(v, at);
        check("t4_att_ff", v, 8'h9F);
        ovr_val = 8'h00;
        wait_sample(v, at);
        check("t4_att_00", v, 8'h60);
        wait_done();
        wait_sample(v, at);
        check("t4_mid_return", v, 8'h80);
        ovr_en = 1'b0; vol = 2'd0;

        // 5: stop beats trig
        pulse_trig(2'd0, 1'b0);
        wait_sample(v, at);
        @(posedge CLK); #1 begin stop = 1'b1; trig = 1'b1; trig_id = 2'd0; end
        @(posedge CLK); #1 begin stop = 1'b0; trig = 1'b0; end
        check("t5_no_ack", trig_ack, 0);
        check("t5_idle", busy, 0);

        // 6: asynchronous reset mid-clip
        pulse_trig(2'd0, 1'b0);
        wait_sample(v, at);
        @(posedge CLK); #3 RESET_N = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_audio", audio_sample_out, 8'h80);
        check("t6_rst_addr", rom_addr, 0);
        check("t6_rst_id", cur_id, 0);
        @(posedge CLK); #3 RESET_N = 1'b1;
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (sample_tick) ticks++;
        end
        check("t6_no_ticks", ticks, 0);
        pulse_trig(2'd3, 1'b0);
        wait_sample(v, at);
        check("t6_restart", v, 8'h00);

        repeat (2) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
